// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer
// Receives ALU requests on a single serial line. A request frame is eight
// data packets carrying operands B then A, followed by one command packet
// carrying the opcode and a CRC-4. Each packet is start(0), type, eight
// payload bits MSB first, stop(1). When the command packet ends, the decoded
// operands, opcode and error flags are presented with a one-cycle valid pulse.

module mtm_alu_deserializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        out_valid,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TYPE,
    ST_PAYLOAD,
    ST_STOP
  } state_e;

  // CRC-4 generator x^4 + x + 1, leading term implicit.
  localparam logic [3:0] CRC_POLY       = 4'b0011;
  localparam logic [3:0] DATA_PKTS      = 4'd8;
  localparam logic [3:0] PKT_CNT_SAT    = 4'd9;
  localparam logic [2:0] ERR_DATA_FLAG  = 3'b100;
  localparam logic [2:0] ERR_CRC_FLAG   = 3'b010;
  localparam logic [2:0] ERR_OP_FLAG    = 3'b001;

  // One serial step of the CRC shift register, message bits MSB first.
  function automatic logic [3:0] crc_step(input logic [3:0] crc, input logic bit_in);
    logic fb;
    fb = crc[3] ^ bit_in;
    return {crc[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'b0000);
  endfunction

  // Only AND, OR, ADD and SUB are supported opcodes.
  function automatic logic op_is_legal(input logic [2:0] op);
    logic legal;
    case (op)
      3'b000, 3'b001, 3'b100, 3'b101: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Packet-level bit FSM.
  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        is_cmd_q, is_cmd_d;
  logic [7:0]  pay_q, pay_d;

  // Frame-level accumulation.
  logic [63:0] data_q, data_d;       // {B, A} once eight data packets are in
  logic [3:0]  pkt_cnt_q, pkt_cnt_d;
  logic        ovf_q, ovf_d;
  logic        frm_q, frm_d;
  logic [3:0]  crc_q, crc_d;

  // Registered outputs.
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_a_q, out_a_d;
  logic [31:0] out_b_q, out_b_d;
  logic [2:0]  out_op_q, out_op_d;
  logic [2:0]  out_err_q, out_err_d;

  // Command-packet decode, valid while the command stop bit is on sin.
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_crc;
  logic        stop_bad;
  logic        err_data;
  logic        err_crc;
  logic        err_op;

  assign cmd_op   = pay_q[6:4];
  assign cmd_crc  = pay_q[3:0];
  assign stop_bad = ~sin;
  assign err_data = (pkt_cnt_q != DATA_PKTS) | ovf_q | frm_q | stop_bad;
  assign err_crc  = (crc_q != cmd_crc);
  assign err_op   = ~op_is_legal(cmd_op);

  // Bit FSM next state: walks start/type/payload/stop and shifts the payload.
  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    is_cmd_d  = is_cmd_q;
    pay_d     = pay_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!sin) state_d = ST_TYPE;
      end
      ST_TYPE: begin
        is_cmd_d  = sin;
        bit_cnt_d = 3'd0;
        state_d   = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        pay_d     = {pay_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Back-to-back packets: IDLE looks for the next start bit right away.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame datapath: CRC accumulation, packet counting, error capture, outputs.
  always_comb begin
    data_d      = data_q;
    pkt_cnt_d   = pkt_cnt_q;
    ovf_d       = ovf_q;
    frm_d       = frm_q;
    crc_d       = crc_q;
    out_valid_d = 1'b0;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_op_d    = out_op_q;
    out_err_d   = out_err_q;

    // CRC covers every data payload bit, then {1'b1, OP}. The command payload
    // is {0, OP, CRC}, so its first bit is replaced by the constant 1 and only
    // the next three bits (OP) are folded in.
    if (state_q == ST_PAYLOAD) begin
      if (!is_cmd_q) begin
        crc_d = crc_step(crc_q, sin);
      end else if (bit_cnt_q == 3'd0) begin
        crc_d = crc_step(crc_q, 1'b1);
      end else if (bit_cnt_q <= 3'd3) begin
        crc_d = crc_step(crc_q, sin);
      end
    end

    if (state_q == ST_STOP) begin
      if (!is_cmd_q) begin
        data_d = {data_q[55:0], pay_q};
        if (pkt_cnt_q == DATA_PKTS) ovf_d = 1'b1;
        if (pkt_cnt_q != PKT_CNT_SAT) pkt_cnt_d = pkt_cnt_q + 4'd1;
        if (stop_bad) frm_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_op_d    = cmd_op;
        if (err_data) begin
          out_err_d = ERR_DATA_FLAG;
        end else if (err_crc) begin
          out_err_d = ERR_CRC_FLAG;
        end else if (err_op) begin
          out_err_d = ERR_OP_FLAG;
        end else begin
          out_err_d = 3'b000;
        end
        // A frame with the wrong shape carries no trustworthy operands.
        if (!err_data) begin
          out_b_d = data_q[63:32];
          out_a_d = data_q[31:0];
        end
        data_d    = '0;
        pkt_cnt_d = '0;
        ovf_d     = 1'b0;
        frm_d     = 1'b0;
        crc_d     = '0;
      end
    end
  end

  // Bit FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      is_cmd_q  <= 1'b0;
      pay_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      is_cmd_q  <= is_cmd_d;
      pay_q     <= pay_d;
    end
  end

  // Frame and output registers; reset discards any partial frame.
  // NOTE: the operand shift register is reset along with the control state so
  // a frame interrupted by reset can never leak bytes into the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      pkt_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      frm_q       <= 1'b0;
      crc_q       <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_op_q    <= '0;
      out_err_q   <= '0;
    end else begin
      data_q      <= data_d;
      pkt_cnt_q   <= pkt_cnt_d;
      ovf_q       <= ovf_d;
      frm_q       <= frm_d;
      crc_q       <= crc_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_op_q    <= out_op_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_op    = out_op_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Testbench for mtm_alu_deserializer: directed frames plus randomized
// back-to-back frames, checked against a frame-level reference model.

module tb_mtm_alu_deserializer;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic        out_valid;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic [2:0]  out_err;

  mtm_alu_deserializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_op    (out_op),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  err;
  } res_t;

  res_t        got_q[$];
  res_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mdl_a = '0;
  logic [31:0] mdl_b = '0;

  // Every negedge on which out_valid is high is one observed result.
  always @(negedge clk) begin
    res_t r;
    if (out_valid) begin
      r.a   = out_a;
      r.b   = out_b;
      r.op  = out_op;
      r.err = out_err;
      got_q.push_back(r);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC as polynomial remainder: msg(x) * x^4 mod (x^4 + x + 1).
  function automatic logic [3:0] crc_ref(input logic [67:0] msg);
    logic [71:0] r;
    r = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  // sin is changed on a negedge and held until the next negedge.
  task automatic send_bit(input logic b);
    sin = b;
    @(negedge clk);
  endtask

  task automatic send_packet(input logic is_cmd, input logic [7:0] payload, input logic stop);
    send_bit(1'b0);
    send_bit(is_cmd);
    for (int j = 7; j >= 0; j--) send_bit(payload[j]);
    send_bit(stop);
  endtask

  // Sends n data packets (bytes of {B,A} in order, wrapping after 8), then the
  // command. bad_stop selects a data packet whose stop bit is sent as 0.
  task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input int n,
                            input logic [2:0] op, input logic [3:0] crc_flip,
                            input int bad_stop);
    logic [63:0] ba;
    logic [3:0]  crc;
    logic [7:0]  byte_v;
    res_t        e;
    logic        shape_bad;
    ba  = {b, a};
    crc = crc_ref({b, a, 1'b1, op}) ^ crc_flip;
    for (int i = 0; i < n; i++) begin
      byte_v = ba[63 - 8 * (i % 8) -: 8];
      send_packet(1'b0, byte_v, (i == bad_stop) ? 1'b0 : 1'b1);
    end
    send_packet(1'b1, {1'b0, op, crc}, 1'b1);
    shape_bad = (n != 8) || (bad_stop >= 0 && bad_stop < n);
    if (shape_bad)                                  e.err = 3'b100;
    else if (crc_flip != 4'b0000)                   e.err = 3'b010;
    else if (!(op == 3'b000 || op == 3'b001 ||
               op == 3'b100 || op == 3'b101))       e.err = 3'b001;
    else                                            e.err = 3'b000;
    if (!shape_bad) begin
      mdl_a = a;
      mdl_b = b;
    end
    e.a  = mdl_a;
    e.b  = mdl_b;
    e.op = op;
    exp_q.push_back(e);
  endtask

  // Lets the last result land, then compares observed and expected results.
  task automatic drain(input string tag);
    res_t g;
    res_t e;
    repeat (3) @(negedge clk);
    check({tag, ".count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, ".a"},   g.a,   e.a);
      check({tag, ".b"},   g.b,   e.b);
      check({tag, ".op"},  g.op,  e.op);
      check({tag, ".err"}, g.err, e.err);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs(input string tag, input logic v, input logic [31:0] a,
                               input logic [31:0] b, input logic [2:0] op,
                               input logic [2:0] err);
    check({tag, ".valid"}, out_valid, v);
    check({tag, ".a"},     out_a,     a);
    check({tag, ".b"},     out_b,     b);
    check({tag, ".op"},    out_op,    op);
    check({tag, ".err"},   out_err,   err);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;
    logic [3:0]  rflip;
    int          rn;
    int          sel;
    logic [2:0]  last_op;
    logic [2:0]  last_err;

    // Reset state.
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs("reset", 1'b0, 32'h0, 32'h0, 3'b000, 3'b000);
    rst_n = 1'b1;

    // Golden frame, started on the first edge after reset release.
    send_frame(32'h1, 32'h2, 8, 3'b100, 4'h0, -1);
    drain("golden");

    // Unsupported opcode with a good CRC.
    send_frame(32'hDEADBEEF, 32'h12345678, 8, 3'b111, 4'h0, -1);
    drain("bad_op");

    // CRC bit 0 flipped; opcode still reported.
    send_frame(32'hA5A5A5A5, 32'h5A5A5A5A, 8, 3'b001, 4'h1, -1);
    drain("bad_crc");

    // Too few data packets: operands hold.
    send_frame(32'h11111111, 32'h22222222, 7, 3'b000, 4'h0, -1);
    drain("short");

    // Too many data packets, then a correct frame straight after.
    send_frame(32'h33333333, 32'h44444444, 9, 3'b101, 4'h0, -1);
    send_frame(32'h0000FFFF, 32'hFFFF0000, 8, 3'b101, 4'h0, -1);
    drain("long_then_ok");

    // Framing error on a data stop bit, then recovery.
    send_frame(32'h77777777, 32'h88888888, 8, 3'b000, 4'h0, 3);
    send_frame(32'h01020304, 32'h05060708, 8, 3'b001, 4'h0, -1);
    drain("framing");

    // Idle line: nothing changes and no pulse appears.
    last_op  = out_op;
    last_err = out_err;
    repeat (40) @(negedge clk);
    check_outputs("idle", 1'b0, mdl_a, mdl_b, last_op, last_err);
    check("idle.pulses", got_q.size(), 0);

    // Reset mid-packet after five data packets, then a full valid frame.
    for (int i = 0; i < 5; i++) send_packet(1'b0, 8'hC3, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    sin   = 1'b1;
    #1;
    check_outputs("midreset", 1'b0, 32'h0, 32'h0, 3'b000, 3'b000);
    mdl_a = '0;
    mdl_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(32'hFFFFFFFF, 32'h80000000, 8, 3'b101, 4'h0, -1);
    drain("after_reset");

    // Randomized frames, back to back in batches of four.
    for (int batch = 0; batch < 5; batch++) begin
      for (int k = 0; k < 4; k++) begin
        ra    = $urandom;
        rb    = $urandom;
        rop   = 3'($urandom_range(0, 7));
        sel   = $urandom_range(0, 9);
        rn    = (sel == 0) ? 7 : (sel == 1) ? 9 : 8;
        rflip = (sel == 2 || sel == 3) ? 4'($urandom_range(1, 15)) : 4'h0;
        send_frame(ra, rb, rn, rop, rflip, (sel == 4) ? int'($urandom_range(0, 7)) : -1);
      end
      drain("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mtm_alu_deserializer.md
MTM_ALU_DESERIALIZER -- requirements
Module: mtm_alu_deserializer

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 sin  in  1  serial ALU request line; idle high; one bit per clk.
REQ-005 out_valid  out  1  one-cycle pulse: request frame complete.
REQ-006 out_a  out  32  operand A.
REQ-007 out_b  out  32  operand B.
REQ-008 out_op  out  3  operation code.
REQ-009 out_err  out  3  error flags {ERR_DATA, ERR_CRC, ERR_OP}; 000 = no error.

Function
REQ-010 Packet: 11 bits, MSB first: start 0, type bit (0 = data, 1 = command), 8 payload bits, stop 1.
REQ-011 Frame: exactly 8 data packets, then 1 command packet.
REQ-012 Data payload order: B[31:24], B[23:16], B[15:8], B[7:0], then A[31:24] to A[7:0].
REQ-013 Command payload: {1'b0, OP[2:0], CRC[3:0]}.
REQ-014 Bit FSM states: IDLE, TYPE, PAYLOAD (8-count), STOP.
REQ-015 FSM transitions: IDLE->TYPE when sin==0; TYPE->PAYLOAD after one cycle; PAYLOAD->STOP after 8 bits; STOP->IDLE after one cycle.
REQ-016 A 4-bit data packet counter increments on each accepted data packet and saturates at 9.
REQ-017 A data packet arriving when the counter is 8 sets a sticky overflow flag.
REQ-018 A stop bit sampled as 0 sets a sticky framing flag.
REQ-019 ERR_DATA on command packet: counter != 8, overflow set, or framing set.
REQ-020 ERR_CRC: CRC-4 (x^4+x+1, init 0000, MSB first) over {B, A, 1'b1, OP} (68 bits) != received CRC.
REQ-021 ERR_OP: OP not in {000 AND, 001 OR, 100 ADD, 101 SUB}.
REQ-022 Error priority: ERR_DATA, then ERR_CRC, then ERR_OP; exactly one bit set when any error is present.
REQ-023 out_valid asserts for exactly one cycle, on the clk after the command packet's stop bit is sampled.
REQ-024 out_a, out_b, out_op and out_err update together with out_valid and hold until the next out_valid.
REQ-025 On an ERR_DATA frame, out_a and out_b hold their previous values.
REQ-026 After each command packet, the counter, overflow flag, framing flag and CRC state clear.
REQ-027 After each command packet, the next frame may start on the cycle immediately following.
REQ-028 Back-to-back packets need no idle gap: sin==0 in IDLE immediately following STOP is a start bit.
REQ-029 sin held high indefinitely leaves the FSM in IDLE with no outputs changing.

Reset
REQ-030 While rst_n==0, all outputs are 0 and the FSM is in IDLE.
REQ-031 While rst_n==0, the counter, flags, CRC state and shift registers are 0.
REQ-032 Reset asserted mid-packet or mid-frame discards the partial frame without asserting out_valid.
REQ-033 The first start bit is recognised on the first rising edge after rst_n deasserts.

Verification
REQ-034 A=1, B=2, OP=100, golden CRC -> one out_valid pulse; out_a=1, out_b=2, out_op=100, out_err=000.
REQ-035 Valid frame with OP=111 and matching CRC -> out_valid, out_err=001.
REQ-036 Valid frame with CRC bit 0 flipped -> out_valid, out_err=010; out_op reflects received OP.
REQ-037 7 data packets then command -> out_err=100.
REQ-038 9 data packets then command -> out_err=100; next correct frame -> out_err=000.
REQ-039 rst_n pulsed low after 5 data packets, then a full valid frame (A=FFFFFFFF, B=80000000, OP=101) -> exactly one out_valid, out_err=000, operands exact.
